// File: rtl/program_sequencer.sv
// Fetch/execute controller for the 4-bit teaching CPU: owns the PC and instruction register,
// and decodes one-cycle datapath strobes, conditional skips and halt-at-end-of-program.
module program_sequencer #(
  parameter int unsigned ADDR_W       = 4,
  parameter bit          HALT_ON_WRAP = 1'b1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [3:0]        romData,
  input  logic              accZero,
  input  logic              shiftZero,
  output logic              loadA,
  output logic              loadB,
  output logic              loadO,
  output logic              loadS,
  output logic              shiftL,
  output logic              shiftR,
  output logic              clr,
  output logic              aluEn,
  output logic [1:0]        aluSel,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegalOp,
  output logic [CNT_W-1:0]  instrCount
);

  typedef enum logic [1:0] {StIdle, StFetch, StExecute, StHalt} state_e;

  localparam logic [3:0] OpLdA = 4'b0000;
  localparam logic [3:0] OpLdB = 4'b0001;
  localparam logic [3:0] OpLdO = 4'b0010;
  localparam logic [3:0] OpLdS = 4'b0011;
  localparam logic [3:0] OpSnzs = 4'b0100;
  localparam logic [3:0] OpShl = 4'b0101;
  localparam logic [3:0] OpShr = 4'b0110;
  localparam logic [3:0] OpClr = 4'b0111;
  localparam logic [3:0] OpSnza = 4'b1000;
  localparam logic [3:0] OpAdd = 4'b1010;
  localparam logic [3:0] OpSub = 4'b1011;
  localparam logic [3:0] OpXor = 4'b1110;

  localparam logic [CNT_W-1:0] CntOne = 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [3:0]          ir_q, ir_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                skip;
  logic [ADDR_W:0]     step;
  logic [ADDR_W:0]     pc_next_wide;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Extra carry bit detects running off the end of the ROM.
  always_comb begin
    skip         = ((ir_q == OpSnza) && !accZero) || ((ir_q == OpSnzs) && !shiftZero);
    step         = '0;
    step[1:0]    = skip ? 2'd2 : 2'd1;
    pc_next_wide = {1'b0, pc_q} + step;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    loadA     = 1'b0;
    loadB     = 1'b0;
    loadO     = 1'b0;
    loadS     = 1'b0;
    shiftL    = 1'b0;
    shiftR    = 1'b0;
    clr       = 1'b0;
    aluEn     = 1'b0;
    aluSel    = 2'b00;

    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        ir_d    = romData;
        state_d = StExecute;
      end
      StExecute: begin
        cnt_d = cnt_q + CntOne;
        case (ir_q)
          OpLdA:  loadA = 1'b1;
          OpLdB:  loadB = 1'b1;
          OpLdO:  loadO = 1'b1;
          OpLdS:  loadS = 1'b1;
          OpShl:  shiftL = 1'b1;
          OpShr:  shiftR = 1'b1;
          OpClr:  clr = 1'b1;
          OpAdd:  aluEn = 1'b1;
          OpSub: begin
            aluEn  = 1'b1;
            aluSel = 2'b01;
          end
          OpXor: begin
            aluEn  = 1'b1;
            aluSel = 2'b10;
          end
          OpSnzs, OpSnza: ;
          default: illegal_d = 1'b1;
        endcase
        if (pc_next_wide[ADDR_W] && HALT_ON_WRAP) begin
          state_d = StHalt;
        end else begin
          pc_d    = pc_next_wide[ADDR_W-1:0];
          state_d = run ? StFetch : StIdle;
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  assign romAddr    = pc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == StHalt);
  assign illegalOp  = illegal_q;
  assign instrCount = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: table-driven per-cycle vectors through a scoreboard queue,
// against a halting instance and a wrapping instance.
module tb_program_sequencer;

  localparam logic [7:0] Z   = 8'h00;
  localparam logic [7:0] LA  = 8'h80;
  localparam logic [7:0] LB  = 8'h40;
  localparam logic [7:0] LO  = 8'h20;
  localparam logic [7:0] LS  = 8'h10;
  localparam logic [7:0] SL  = 8'h08;
  localparam logic [7:0] SR  = 8'h04;
  localparam logic [7:0] CL  = 8'h02;
  localparam logic [7:0] ALU = 8'h01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, run, accZero, shiftZero;
  logic [3:0] rom [16];
  logic [3:0] rom_w [16];

  logic [3:0] addr_h, data_h, pc_h;
  logic       la_h, lb_h, lo_h, ls_h, sl_h, sr_h, cl_h, alu_h, halt_h, ill_h;
  logic [1:0] sel_h;
  logic [7:0] cnt_h;

  logic [3:0] addr_w, data_w, pc_w;
  logic       la_w, lb_w, lo_w, ls_w, sl_w, sr_w, cl_w, alu_w, halt_w, ill_w;
  logic [1:0] sel_w;
  logic [7:0] cnt_w;

  assign data_h = rom[addr_h];
  assign data_w = rom_w[addr_w];

  program_sequencer #(.ADDR_W(4), .HALT_ON_WRAP(1'b1), .CNT_W(8)) dut_h (
    .clk(clk), .reset(reset), .run(run), .romAddr(addr_h), .romData(data_h),
    .accZero(accZero), .shiftZero(shiftZero), .loadA(la_h), .loadB(lb_h), .loadO(lo_h),
    .loadS(ls_h), .shiftL(sl_h), .shiftR(sr_h), .clr(cl_h), .aluEn(alu_h), .aluSel(sel_h),
    .pc(pc_h), .halted(halt_h), .illegalOp(ill_h), .instrCount(cnt_h)
  );

  program_sequencer #(.ADDR_W(4), .HALT_ON_WRAP(1'b0), .CNT_W(8)) dut_w (
    .clk(clk), .reset(reset), .run(run), .romAddr(addr_w), .romData(data_w),
    .accZero(accZero), .shiftZero(shiftZero), .loadA(la_w), .loadB(lb_w), .loadO(lo_w),
    .loadS(ls_w), .shiftL(sl_w), .shiftR(sr_w), .clr(cl_w), .aluEn(alu_w), .aluSel(sel_w),
    .pc(pc_w), .halted(halt_w), .illegalOp(ill_w), .instrCount(cnt_w)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       run;
    logic       az;
    logic       sz;
    logic       w;
    logic [7:0] stb;
    logic [1:0] sel;
    logic [3:0] pc;
    logic       halt;
    logic       ill;
    logic [7:0] cnt;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(string n, logic rst, logic rn, logic az, logic sz, logic w,
                              logic [7:0] stb, logic [1:0] sel, logic [3:0] p, logic halt,
                              logic ill, logic [7:0] cnt);
    vec_t v;
    v.name = n; v.rst = rst; v.run = rn; v.az = az; v.sz = sz; v.w = w;
    v.stb = stb; v.sel = sel; v.pc = p; v.halt = halt; v.ill = ill; v.cnt = cnt;
    return v;
  endfunction

  task automatic check_out();
    vec_t        e;
    logic [27:0] act, exp;
    e = sb.pop_front();
    if (e.w) act = {la_w, lb_w, lo_w, ls_w, sl_w, sr_w, cl_w, alu_w, sel_w, pc_w, addr_w,
                    halt_w, ill_w, cnt_w};
    else     act = {la_h, lb_h, lo_h, ls_h, sl_h, sr_h, cl_h, alu_h, sel_h, pc_h, addr_h,
                    halt_h, ill_h, cnt_h};
    exp = {e.stb, e.sel, e.pc, e.pc, e.halt, e.ill, e.cnt};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got stb=%b sel=%b pc=%0d addr=%0d halt=%b ill=%b cnt=%0d, want stb=%b sel=%b pc=%0d halt=%b ill=%b cnt=%0d",
               e.name, act[27:20], act[19:18], act[17:14], act[13:10], act[9], act[8],
               act[7:0], e.stb, e.sel, e.pc, e.halt, e.ill, e.cnt);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; run = v.run; accZero = v.az; shiftZero = v.sz;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  function automatic logic [3:0] prog_b(int k);
    if (k == 0) return 4'b0000;
    if (k == 1) return 4'b0011;
    if (k == 2) return 4'b1101;
    return (k % 2 == 1) ? 4'b1110 : 4'b0010;
  endfunction

  function automatic logic [7:0] stb_b(int k);
    if (k == 0) return LA;
    if (k == 1) return LS;
    if (k == 2) return Z;
    return (k % 2 == 1) ? ALU : LO;
  endfunction

  initial begin
    reset = 1'b1; run = 1'b0; accZero = 1'b1; shiftZero = 1'b1;
    rom[0] = 4'b0000; rom[1] = 4'b0001; rom[2] = 4'b1010; rom[3] = 4'b0010;
    rom[4] = 4'b1000; rom[5] = 4'b0011; rom[6] = 4'b0101; rom[7] = 4'b0110;
    for (int i = 8; i < 16; i++) rom[i] = 4'b0111;
    for (int i = 0; i < 16; i++) rom_w[i] = 4'b0001;
    rom_w[15] = 4'b0100;

    // name rst run az sz w | stb sel pc halt ill cnt
    tbl.push_back(mk("a_reset",     1, 0, 1, 1, 0, Z,   0, 0, 0, 0, 0));
    tbl.push_back(mk("a_fetch0",    0, 1, 1, 1, 0, Z,   0, 0, 0, 0, 0));
    tbl.push_back(mk("a_ldA",       0, 1, 1, 1, 0, LA,  0, 0, 0, 0, 0));
    tbl.push_back(mk("a_fetch1",    0, 1, 1, 1, 0, Z,   0, 1, 0, 0, 1));
    tbl.push_back(mk("a_ldB",       0, 1, 1, 1, 0, LB,  0, 1, 0, 0, 1));
    tbl.push_back(mk("a_fetch2",    0, 1, 1, 1, 0, Z,   0, 2, 0, 0, 2));
    tbl.push_back(mk("a_add",       0, 1, 1, 1, 0, ALU, 0, 2, 0, 0, 2));
    tbl.push_back(mk("a_fetch3",    0, 1, 1, 1, 0, Z,   0, 3, 0, 0, 3));
    tbl.push_back(mk("a_ldO",       0, 1, 1, 1, 0, LO,  0, 3, 0, 0, 3));
    tbl.push_back(mk("a_fetch4",    0, 1, 1, 1, 0, Z,   0, 4, 0, 0, 4));
    tbl.push_back(mk("a_snza_ex",   0, 1, 0, 1, 0, Z,   0, 4, 0, 0, 4));
    tbl.push_back(mk("a_skip_pc6",  0, 1, 0, 1, 0, Z,   0, 6, 0, 0, 5));
    tbl.push_back(mk("a_shl",       0, 1, 1, 1, 0, SL,  0, 6, 0, 0, 5));
    tbl.push_back(mk("a_fetch7",    0, 1, 1, 1, 0, Z,   0, 7, 0, 0, 6));
    tbl.push_back(mk("a_run_drop",  0, 0, 1, 1, 0, SR,  0, 7, 0, 0, 6));
    tbl.push_back(mk("a_idle",      0, 0, 1, 1, 0, Z,   0, 8, 0, 0, 7));
    tbl.push_back(mk("a_idle_hold", 0, 0, 1, 1, 0, Z,   0, 8, 0, 0, 7));
    tbl.push_back(mk("a_refetch",   0, 1, 1, 1, 0, Z,   0, 8, 0, 0, 7));
    tbl.push_back(mk("a_clr",       0, 1, 1, 1, 0, CL,  0, 8, 0, 0, 7));
    tbl.push_back(mk("a_rst_exec",  1, 1, 1, 1, 0, Z,   0, 0, 0, 0, 0));
    tbl.push_back(mk("b_fetch0",    0, 1, 1, 1, 0, Z,   0, 0, 0, 0, 0));
    tbl.push_back(mk("b_ldA",       0, 1, 1, 1, 0, LA,  0, 0, 0, 0, 0));
    tbl.push_back(mk("b_fetch1",    0, 1, 1, 1, 0, Z,   0, 1, 0, 0, 1));
    tbl.push_back(mk("b_ldB",       0, 1, 1, 1, 0, LB,  0, 1, 0, 0, 1));
    tbl.push_back(mk("b_fetch2",    0, 1, 1, 1, 0, Z,   0, 2, 0, 0, 2));
    tbl.push_back(mk("b_add",       0, 1, 1, 1, 0, ALU, 0, 2, 0, 0, 2));
    tbl.push_back(mk("b_fetch3",    0, 1, 1, 1, 0, Z,   0, 3, 0, 0, 3));
    tbl.push_back(mk("b_ldO",       0, 1, 1, 1, 0, LO,  0, 3, 0, 0, 3));
    tbl.push_back(mk("b_fetch4",    0, 1, 1, 1, 0, Z,   0, 4, 0, 0, 4));
    tbl.push_back(mk("b_snza_ex",   0, 1, 1, 1, 0, Z,   0, 4, 0, 0, 4));
    tbl.push_back(mk("b_noskip_pc5", 0, 1, 1, 1, 0, Z,  0, 5, 0, 0, 5));
    tbl.push_back(mk("b_ldS",       0, 1, 1, 1, 0, LS,  0, 5, 0, 0, 5));
    tbl.push_back(mk("b_fetch6",    0, 1, 1, 1, 0, Z,   0, 6, 0, 0, 6));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Full 16-entry program with an illegal opcode at pc=2; halts after pc=15.
    for (int i = 0; i < 16; i++) rom[i] = prog_b(i);
    apply(mk("c_reset", 1, 0, 1, 1, 0, Z, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++) begin
      apply(mk($sformatf("c_fetch%0d", k), 0, 1, 1, 1, 0, Z, 2'b00, 4'(k), 0, (k > 2),
               8'(k)));
      apply(mk($sformatf("c_exec%0d", k), 0, 1, 1, 1, 0, stb_b(k),
               ((k > 2) && (k % 2 == 1)) ? 2'b10 : 2'b00, 4'(k), 0, (k > 2), 8'(k)));
    end
    for (int i = 0; i < 12; i++)
      apply(mk($sformatf("c_halt%0d", i), 0, 1, 0, 0, 0, Z, 0, 15, 1, 1, 16));
    apply(mk("c_reset_clears", 1, 0, 1, 1, 0, Z, 0, 0, 0, 0, 0));

    // Wrapping instance: SNZS at pc=15 with shiftZero=0 goes to pc=1 without halting.
    apply(mk("d_reset", 1, 0, 1, 1, 1, Z, 0, 0, 0, 0, 0));
    for (int k = 0; k < 15; k++) begin
      apply(mk($sformatf("d_fetch%0d", k), 0, 1, 1, 1, 1, Z, 0, 4'(k), 0, 0, 8'(k)));
      apply(mk($sformatf("d_exec%0d", k), 0, 1, 1, 1, 1, LB, 0, 4'(k), 0, 0, 8'(k)));
    end
    apply(mk("d_fetch15", 0, 1, 1, 0, 1, Z,  0, 15, 0, 0, 15));
    apply(mk("d_snzs_ex", 0, 1, 1, 0, 1, Z,  0, 15, 0, 0, 15));
    apply(mk("d_wrap_pc1", 0, 1, 1, 0, 1, Z, 0, 1, 0, 0, 16));
    apply(mk("d_exec1",   0, 1, 1, 1, 1, LB, 0, 1, 0, 0, 16));
    apply(mk("d_fetch2",  0, 1, 1, 1, 1, Z,  0, 2, 0, 0, 17));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
